// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Function : Runs a W-bit operation through one external 4-bit ALU slice,
//            one nibble per clock, rippling the carry between slices.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   cn_n,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   f,
    output logic                   cout_n,
    output logic                   eq,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cn_n,
    input  logic [3:0]             alu_f,
    input  logic                   alu_cnplus,
    input  logic                   alu_eq
);

    localparam int c_W  = 4 * NIBBLES;
    localparam int c_CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic [3:0]        r_s;
    logic              r_m;
    logic              r_carry_n;
    logic              r_eq_acc;
    logic [c_W-1:0]    r_f_acc;

    logic [c_CW+1:0]   w_base;
    logic [c_W-1:0]    w_f_next;

    // Accumulator with the current slice result merged in, so the final edge
    // can publish all nibbles including the one being computed right now.
    always_comb begin
        w_base   = {r_cnt, 2'b00};
        w_f_next = r_f_acc;
        w_f_next[w_base +: 4] = alu_f;
    end

    always_comb begin
        alu_a    = 4'd0;
        alu_b    = 4'd0;
        alu_s    = 4'd0;
        alu_m    = 1'b0;
        alu_cn_n = 1'b1;
        if (r_state == S_RUN) begin
            alu_a    = r_a[w_base +: 4];
            alu_b    = r_b[w_base +: 4];
            alu_s    = r_s;
            alu_m    = r_m;
            alu_cn_n = r_carry_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= 4'd0;
            r_m       <= 1'b0;
            r_carry_n <= 1'b1;
            r_eq_acc  <= 1'b0;
            r_f_acc   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            f         <= '0;
            cout_n    <= 1'b1;
            eq        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_s       <= op_s;
                        r_m       <= op_m;
                        r_carry_n <= cn_n;
                        r_eq_acc  <= 1'b1;
                        r_cnt     <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_f_acc   <= w_f_next;
                    r_carry_n <= alu_cnplus;
                    r_eq_acc  <= r_eq_acc & alu_eq;
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        f       <= w_f_next;
                        cout_n  <= alu_cnplus;
                        eq      <= r_eq_acc & alu_eq;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Function : Bench for alu_seq_ctrl with a 74181-style slice emulator and a
//            word-level reference model of the same function table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int c_N = 4;
    localparam int c_W = 4 * c_N;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       op_s;
    logic             op_m;
    logic             cn_n;
    logic [c_W-1:0]   a;
    logic [c_W-1:0]   b;
    logic             busy;
    logic             done;
    logic [c_W-1:0]   f;
    logic             cout_n;
    logic             eq;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_cn_n;
    logic [3:0]       alu_f;
    logic             alu_cnplus;
    logic             alu_eq;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [c_W-1:0] r_cur_f;

    alu_seq_ctrl #(.NIBBLES(c_N)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_s(op_s), .op_m(op_m),
        .cn_n(cn_n), .a(a), .b(b), .busy(busy), .done(done), .f(f),
        .cout_n(cout_n), .eq(eq), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_m(alu_m), .alu_cn_n(alu_cn_n), .alu_f(alu_f),
        .alu_cnplus(alu_cnplus), .alu_eq(alu_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] logic_fn(input logic [3:0] s,
                                             input logic [15:0] x,
                                             input logic [15:0] y);
        case (s)
            4'h0: logic_fn = ~x;
            4'h1: logic_fn = ~(x | y);
            4'h2: logic_fn = ~x & y;
            4'h3: logic_fn = 16'h0000;
            4'h4: logic_fn = ~(x & y);
            4'h5: logic_fn = ~y;
            4'h6: logic_fn = x ^ y;
            4'h7: logic_fn = x & ~y;
            4'h8: logic_fn = ~x | y;
            4'h9: logic_fn = ~(x ^ y);
            4'hA: logic_fn = y;
            4'hB: logic_fn = x & y;
            4'hC: logic_fn = 16'hFFFF;
            4'hD: logic_fn = x | ~y;
            4'hE: logic_fn = x | y;
            default: logic_fn = x;
        endcase
    endfunction

    // 4-bit slice emulator: sum of two select-gated terms plus carry-in.
    logic [3:0] w_x, w_y, w_lg;
    logic [4:0] w_sum;
    always_comb begin
        w_x   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        w_y   = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'd0, ~alu_cn_n};
        w_lg  = logic_fn(alu_s, {12'd0, alu_a}, {12'd0, alu_b}) & 16'h000F;
    end
    assign alu_f      = alu_m ? w_lg : w_sum[3:0];
    assign alu_cnplus = ~w_sum[4];
    assign alu_eq     = (alu_f == 4'hF);

    // Word-level reference from the function table written as plain arithmetic.
    task automatic model(input logic [3:0] s, input logic m, input logic cin_n,
                         input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] ef, output logic eco_n,
                         output logic eeq);
        logic [16:0] c, ax, bx, nb, ones, r;
        c    = {16'd0, ~cin_n};
        ax   = {1'b0, x};
        bx   = {1'b0, y};
        nb   = {1'b0, ~y};
        ones = 17'h0FFFF;
        case (s)
            4'h0: r = ax + c;
            4'h1: r = (ax | bx) + c;
            4'h2: r = (ax | nb) + c;
            4'h3: r = ones + c;
            4'h4: r = ax + (ax & nb) + c;
            4'h5: r = (ax | bx) + (ax & nb) + c;
            4'h6: r = ax + nb + c;
            4'h7: r = (ax & nb) + ones + c;
            4'h8: r = ax + (ax & bx) + c;
            4'h9: r = ax + bx + c;
            4'hA: r = (ax | nb) + (ax & bx) + c;
            4'hB: r = (ax & bx) + ones + c;
            4'hC: r = ax + ax + c;
            4'hD: r = (ax | bx) + ax + c;
            4'hE: r = (ax | nb) + ax + c;
            default: r = ax + ones + c;
        endcase
        ef    = m ? logic_fn(s, x, y) : r[15:0];
        eco_n = ~r[16];
        eeq   = (ef == 16'hFFFF);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] s, input logic m, input logic cin_n,
                          input logic [15:0] x, input logic [15:0] y);
        logic [15:0] ef;
        logic        eco, eeq;
        int          lat;
        model(s, m, cin_n, x, y, ef, eco, eeq);
        op_s = s; op_m = m; cn_n = cin_n; a = x; b = y; start = 1'b1;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            if (lat == 1) begin
                check("busy_run", {31'd0, busy}, 32'd1);
                check("alu_a0", {28'd0, alu_a}, {28'd0, x[3:0]});
                check("alu_b0", {28'd0, alu_b}, {28'd0, y[3:0]});
                check("alu_s", {28'd0, alu_s}, {28'd0, s});
                check("alu_m", {31'd0, alu_m}, {31'd0, m});
                check("alu_cn0", {31'd0, alu_cn_n}, {31'd0, cin_n});
            end
            if (done) break;
            check("f_held", {16'd0, f}, {16'd0, r_cur_f});
        end
        check("latency", lat, c_N + 1);
        check("f", {16'd0, f}, {16'd0, ef});
        check("cout_n", {31'd0, cout_n}, {31'd0, eco});
        check("eq", {31'd0, eq}, {31'd0, eeq});
        check("busy_done", {31'd0, busy}, 32'd1);
        r_cur_f = ef;
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("alu_idle", {27'd0, alu_a, alu_cn_n}, 32'd1);
        check("f_keep", {16'd0, f}, {16'd0, r_cur_f});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ef;
        logic        eco, eeq;
        rst = 1'b1; start = 1'b1; op_s = 4'h9; op_m = 1'b0; cn_n = 1'b1;
        a = 16'h1234; b = 16'h0FFF; r_cur_f = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_f", {16'd0, f}, 32'd0);
        check("rst_cout", {31'd0, cout_n}, 32'd1);
        check("rst_eq", {31'd0, eq}, 32'd0);
        check("rst_alu", {18'd0, alu_a, alu_b, alu_s, alu_m, alu_cn_n}, 32'd1);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {31'd0, busy}, 32'd0);

        run_op(4'h9, 1'b0, 1'b1, 16'h1234, 16'h0FFF);
        check("add_f", {16'd0, f}, 32'h2233);
        check("add_cout", {31'd0, cout_n}, 32'd1);
        run_op(4'h9, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
        check("ripple_f", {16'd0, f}, 32'h0000);
        check("ripple_cout", {31'd0, cout_n}, 32'd0);
        run_op(4'h6, 1'b0, 1'b0, 16'h5000, 16'h1000);
        check("sub_f", {16'd0, f}, 32'h4000);
        check("sub_cout", {31'd0, cout_n}, 32'd0);
        run_op(4'h6, 1'b0, 1'b1, 16'hABCD, 16'hABCD);
        check("cmp_f", {16'd0, f}, 32'hFFFF);
        check("cmp_eq", {31'd0, eq}, 32'd1);
        run_op(4'h6, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
        check("xor_f", {16'd0, f}, 32'h0FF0);
        check("xor_eq", {31'd0, eq}, 32'd0);
        run_op(4'h9, 1'b1, 1'b1, 16'hFFFF, 16'h0001);

        for (int i = 0; i < 24; i++)
            run_op(4'($urandom), 1'($urandom), 1'($urandom),
                   16'($urandom), 16'($urandom));

        // Start held high for five cycles: only the first request executes.
        op_s = 4'h9; op_m = 1'b0; cn_n = 1'b0; a = 16'h0F0F; b = 16'h1111;
        model(4'h9, 1'b0, 1'b0, 16'h0F0F, 16'h1111, ef, eco, eeq);
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("b2b_busy", {31'd0, busy}, 32'd1);
            check("b2b_nodone", {31'd0, done}, 32'd0);
            op_s = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_f", {16'd0, f}, {16'd0, ef});
        r_cur_f = ef;
        @(negedge clk);
        check("b2b_idle", {31'd0, busy}, 32'd0);
        run_op(4'hC, 1'b0, 1'b1, 16'h4321, 16'h0000);
        check("b2b_new_f", {16'd0, f}, 32'h8642);

        // Reset in the second RUN cycle aborts the operation.
        op_s = 4'h9; op_m = 1'b0; cn_n = 1'b1; a = 16'h1111; b = 16'h2222;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_f", {16'd0, f}, 32'd0);
        check("abort_cout", {31'd0, cout_n}, 32'd1);
        r_cur_f = 16'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_nodone", {30'd0, done, busy}, 32'd0);
        end
        run_op(4'h9, 1'b0, 1'b1, 16'h1111, 16'h2222);
        check("post_abort_f", {16'd0, f}, 32'h3333);

        // Reset has priority over a simultaneous start.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rst_prio_idle", {30'd0, busy, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
